// File: rtl/i2c_slave_regbank.sv
// I2C target with a 2**ADDR_W byte register bank, pointer byte and auto-incrementing bursts.
// Optional: define I2C_GENERAL_CALL_EN to ACK general-call writes (address byte 0x00).
module i2c_slave_regbank #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
    parameter int unsigned ADDR_W      = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              sda,
    output logic              slave_sda_en,
    output logic              ssda_buffer,
    output logic              ack_err,
    output logic              done,
    output logic              busy,
    output logic              reg_wr_en,
    output logic [ADDR_W-1:0] reg_wr_addr,
    output logic [7:0]        reg_wr_data
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [3:0] {
        StIdle, StAddr, StAddrAck, StPtr, StWrite, StDataAck, StRead, StMack, StWaitStop
    } state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [7:0]          shreg_q, shreg_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic                rw_q, rw_d;
    logic                phase_q, phase_d;
    logic                mack_q, mack_d;
    logic                sda_en_q, sda_en_d;
    logic                sda_out_q, sda_out_d;
    logic                ack_err_q, ack_err_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                wr_en;
    logic [7:0]          bank_q [DEPTH];

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic scl_prev_q, sda_prev_q;
    logic scl_s, sda_s, scl_rise, scl_fall, start_ev, stop_ev;
    logic addr_match, mid_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], sclk};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
            scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
            sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
        end
    end

    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s & scl_prev_q;
    assign start_ev = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_ev  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    // The SCL rise that frames a START/STOP was itself counted, so 1..7 real bits is 2..8.
    assign mid_byte = ((state_q == StPtr) || (state_q == StWrite) || (state_q == StRead))
                      && (cnt_q > 4'd1);

    always_comb begin
        addr_match = (shreg_q[7:1] == SLAVE_ADDR);
`ifdef I2C_GENERAL_CALL_EN
        if (shreg_q == 8'h00) addr_match = 1'b1;
`endif
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        phase_d   = phase_q;
        mack_d    = mack_q;
        sda_en_d  = sda_en_q;
        sda_out_d = sda_out_q;
        ack_err_d = ack_err_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        wr_en     = 1'b0;
        if (stop_ev) begin
            state_d   = StIdle;
            cnt_d     = 4'd0;
            phase_d   = 1'b0;
            sda_en_d  = 1'b0;
            sda_out_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = busy_q;
            if (mid_byte) ack_err_d = 1'b1;
        end else if (start_ev) begin
            state_d   = StAddr;
            cnt_d     = 4'd0;
            phase_d   = 1'b0;
            sda_en_d  = 1'b0;
            sda_out_d = 1'b0;
            ack_err_d = mid_byte;
        end else begin
            unique case (state_q)
                StIdle, StWaitStop: begin
                end
                StAddr, StPtr, StWrite: begin
                    if (scl_rise && (cnt_q < 4'd8)) begin
                        shreg_d = {shreg_q[6:0], sda_s};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (cnt_q == 4'd8) begin
                        phase_d = 1'b0;
                        if (state_q == StAddr) begin
                            if (addr_match) begin
                                busy_d  = 1'b1;
                                rw_d    = shreg_q[0];
                                state_d = StAddrAck;
                            end else begin
                                state_d = StIdle;
                            end
                        end else if (state_q == StPtr) begin
                            ptr_d   = shreg_q[ADDR_W-1:0];
                            state_d = StDataAck;
                        end else begin
                            wr_en   = 1'b1;
                            ptr_d   = ptr_q + ADDR_W'(1);
                            state_d = StDataAck;
                        end
                    end
                end
                StAddrAck, StDataAck: begin
                    if (scl_fall) begin
                        if (!phase_q) begin
                            phase_d   = 1'b1;
                            sda_en_d  = 1'b1;
                            sda_out_d = 1'b0;
                        end else begin
                            phase_d  = 1'b0;
                            sda_en_d = 1'b0;
                            cnt_d    = 4'd0;
                            if (state_q == StDataAck) state_d = StWrite;
                            else state_d = rw_q ? StRead : StPtr;
                        end
                    end
                end
                StRead: begin
                    // phase_q low: byte not yet loaded; load and present MSB while SCL is low
                    if (!phase_q) begin
                        shreg_d   = bank_q[ptr_q];
                        sda_out_d = bank_q[ptr_q][7];
                        sda_en_d  = 1'b1;
                        ptr_d     = ptr_q + ADDR_W'(1);
                        phase_d   = 1'b1;
                        cnt_d     = 4'd0;
                    end else if (scl_rise) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (cnt_q == 4'd8) begin
                            sda_en_d  = 1'b0;
                            sda_out_d = 1'b0;
                            phase_d   = 1'b0;
                            state_d   = StMack;
                        end else begin
                            shreg_d   = {shreg_q[6:0], 1'b0};
                            sda_out_d = shreg_q[6];
                        end
                    end
                end
                StMack: begin
                    if (scl_rise) begin
                        phase_d = 1'b1;
                        mack_d  = sda_s;
                    end else if (scl_fall && phase_q) begin
                        phase_d = 1'b0;
                        state_d = mack_q ? StWaitStop : StRead;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            shreg_q   <= 8'h00;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            phase_q   <= 1'b0;
            mack_q    <= 1'b0;
            sda_en_q  <= 1'b0;
            sda_out_q <= 1'b0;
            ack_err_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) bank_q[i] <= 8'(i);
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            phase_q   <= phase_d;
            mack_q    <= mack_d;
            sda_en_q  <= sda_en_d;
            sda_out_q <= sda_out_d;
            ack_err_q <= ack_err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            if (wr_en) bank_q[ptr_q] <= shreg_q;
        end
    end

    assign slave_sda_en = sda_en_q;
    assign ssda_buffer  = sda_out_q;
    assign ack_err      = ack_err_q;
    assign done         = done_q;
    assign busy         = busy_q;
    assign reg_wr_en    = wr_en;
    assign reg_wr_addr  = ptr_q;
    assign reg_wr_data  = shreg_q;

endmodule

// File: tb/tb_i2c_slave_regbank.sv
// Bench for i2c_slave_regbank: bit-banged I2C master against a transaction-level bank model.
`timescale 1ns/1ps
module tb_i2c_slave_regbank;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;
    localparam int Q      = 40;

    logic clk, rst, scl, m_sda, sda_bus;
    logic slave_sda_en, ssda_buffer, ack_err, done, busy, reg_wr_en;
    logic [ADDR_W-1:0] reg_wr_addr;
    logic [7:0] reg_wr_data;

    int checks = 0;
    int failures = 0;

    i2c_slave_regbank dut (
        .clk(clk), .rst(rst), .sclk(scl), .sda(sda_bus),
        .slave_sda_en(slave_sda_en), .ssda_buffer(ssda_buffer), .ack_err(ack_err),
        .done(done), .busy(busy), .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data)
    );

    // Open-drain bus: either side can pull low.
    assign sda_bus = m_sda & (slave_sda_en ? ssda_buffer : 1'b1);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int wr_cnt = 0;
    int done_cnt = 0;
    logic sda_en_seen = 1'b0;
    logic [ADDR_W+7:0] wr_q [$];
    always @(negedge clk) begin
        if (reg_wr_en === 1'b1) begin
            wr_cnt++;
            wr_q.push_back({reg_wr_addr, reg_wr_data});
        end
        if (done === 1'b1) done_cnt++;
        if (slave_sda_en === 1'b1) sda_en_seen = 1'b1;
    end

    logic [7:0] model_bank [DEPTH];
    int model_ptr;
    logic [7:0] tx_q [$];
    logic [7:0] rx_q [$];

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) model_bank[i] = 8'(i);
        model_ptr = 0;
    endfunction

    function automatic void model_write(input int p);
        model_ptr = p;
        foreach (tx_q[k]) begin
            model_bank[model_ptr] = tx_q[k];
            model_ptr = (model_ptr + 1) % DEPTH;
        end
    endfunction

    function automatic void clear_mon();
        wr_cnt = 0;
        done_cnt = 0;
        sda_en_seen = 1'b0;
        wr_q.delete();
    endfunction

    task automatic i2c_start();
        m_sda = 1'b1; #(Q); scl = 1'b1; #(Q); m_sda = 1'b0; #(Q); scl = 1'b0; #(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; #(Q); scl = 1'b1; #(Q); m_sda = 1'b1; #(2*Q);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b; #(Q); scl = 1'b1; #(2*Q); scl = 1'b0; #(Q);
    endtask

    task automatic recv_bit(output logic b);
        m_sda = 1'b1; #(Q); scl = 1'b1; #(Q); b = sda_bus; #(Q); scl = 1'b0; #(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic nak);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        recv_bit(nak);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nak);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(b);
            d[i] = b;
        end
        send_bit(nak);
    endtask

    task automatic do_write(input logic [7:0] p, output int naks);
        logic a;
        naks = 0;
        i2c_start();
        write_byte(8'hA0, a); naks += int'(a);
        write_byte(p, a);     naks += int'(a);
        foreach (tx_q[k]) begin
            write_byte(tx_q[k], a);
            naks += int'(a);
        end
        i2c_stop();
    endtask

    task automatic do_read(input logic [7:0] p, input int n, output int naks);
        logic a;
        logic [7:0] d;
        naks = 0;
        rx_q.delete();
        i2c_start();
        write_byte(8'hA0, a); naks += int'(a);
        write_byte(p, a);     naks += int'(a);
        i2c_start();
        write_byte(8'hA1, a); naks += int'(a);
        for (int k = 0; k < n; k++) begin
            read_byte(d, k == n - 1);
            rx_q.push_back(d);
        end
        i2c_stop();
    endtask

    task automatic test_reset();
        int naks;
        #3;
        checks++;
        if ({slave_sda_en, ssda_buffer, ack_err, done, busy, reg_wr_en, reg_wr_addr, reg_wr_data}
            !== 17'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b want all zero",
                     {slave_sda_en, ssda_buffer, ack_err, done, busy, reg_wr_en});
        end
        repeat (5) @(posedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        model_reset();
        do_read(8'h00, DEPTH, naks);
        checks++;
        if (naks != 0) begin failures++; $display("FAIL reset_read_acks: got %0d naks want 0", naks); end
        for (int k = 0; k < DEPTH; k++) begin
            checks++;
            if (rx_q[k] !== model_bank[k]) begin
                failures++;
                $display("FAIL reset_bank[%0d]: got %h want %h", k, rx_q[k], model_bank[k]);
            end
        end
        model_ptr = 0;
    endtask

    task automatic test_write_burst();
        logic a;
        int naks = 0;
        logic [7:0] d;
        clear_mon();
        tx_q = '{8'hA5, 8'h3C};
        i2c_start();
        write_byte(8'hA0, a); naks += int'(a);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL burst_busy: got %b want 1", busy); end
        write_byte(8'h02, a); naks += int'(a);
        write_byte(8'hA5, a); naks += int'(a);
        write_byte(8'h3C, a); naks += int'(a);
        i2c_stop();
        repeat (4) @(posedge clk);
        model_write(2);
        checks++;
        if (naks != 0) begin failures++; $display("FAIL burst_acks: got %0d naks want 0", naks); end
        checks++;
        if (wr_cnt != 2) begin failures++; $display("FAIL burst_wr_cnt: got %0d want 2", wr_cnt); end
        for (int k = 0; k < 2 && k < wr_q.size(); k++) begin
            checks++;
            if (wr_q[k] !== {3'(2 + k), tx_q[k]}) begin
                failures++;
                $display("FAIL burst_wr[%0d]: got %h want %h", k, wr_q[k], {3'(2 + k), tx_q[k]});
            end
        end
        checks++;
        if (done_cnt != 1) begin failures++; $display("FAIL burst_done: got %0d want 1", done_cnt); end
        checks++;
        if ({busy, ack_err} !== 2'b00) begin
            failures++;
            $display("FAIL burst_busy_err: got %b want 00", {busy, ack_err});
        end
        // Plain read without pointer byte starts at the retained pointer.
        i2c_start();
        write_byte(8'hA1, a);
        read_byte(d, 1'b1);
        i2c_stop();
        checks++;
        if (d !== model_bank[model_ptr]) begin
            failures++;
            $display("FAIL burst_ptr_read: got %h want %h", d, model_bank[model_ptr]);
        end
        model_ptr = (model_ptr + 1) % DEPTH;
    endtask

    task automatic test_read_restart();
        logic a;
        int naks = 0;
        logic [7:0] d0, d1;
        clear_mon();
        i2c_start();
        write_byte(8'hA0, a); naks += int'(a);
        write_byte(8'h05, a); naks += int'(a);
        i2c_start();
        write_byte(8'hA1, a); naks += int'(a);
        read_byte(d0, 1'b0);
        read_byte(d1, 1'b1);
        checks++;
        if (slave_sda_en !== 1'b0) begin
            failures++;
            $display("FAIL rd_release: got %b want 0", slave_sda_en);
        end
        i2c_stop();
        repeat (4) @(posedge clk);
        model_ptr = 7;
        checks++;
        if (naks != 0) begin failures++; $display("FAIL rd_acks: got %0d naks want 0", naks); end
        checks++;
        if ({d0, d1} !== {model_bank[5], model_bank[6]}) begin
            failures++;
            $display("FAIL rd_data: got %h %h want %h %h", d0, d1, model_bank[5], model_bank[6]);
        end
        checks++;
        if (done_cnt != 1) begin failures++; $display("FAIL rd_done: got %0d want 1", done_cnt); end
        checks++;
        if (ack_err !== 1'b0) begin failures++; $display("FAIL rd_ack_err: got %b want 0", ack_err); end
    endtask

    task automatic test_wrap();
        int naks;
        tx_q = '{8'h11, 8'h22};
        do_write(8'h07, naks);
        model_write(7);
        do_read(8'h07, 2, naks);
        model_ptr = 1;
        checks++;
        if ({rx_q[0], rx_q[1]} !== {model_bank[7], model_bank[0]}) begin
            failures++;
            $display("FAIL wrap_data: got %h %h want %h %h", rx_q[0], rx_q[1],
                     model_bank[7], model_bank[0]);
        end
    endtask

    task automatic test_mismatch();
        logic a0, a1;
        int naks;
        clear_mon();
        i2c_start();
        write_byte(8'hA4, a0);
        write_byte(8'h01, a1);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL mm_busy: got %b want 0", busy); end
        i2c_stop();
        repeat (4) @(posedge clk);
        checks++;
        if ({a0, a1} !== 2'b11) begin failures++; $display("FAIL mm_nak: got %b want 11", {a0, a1}); end
        checks++;
        if (sda_en_seen !== 1'b0) begin
            failures++;
            $display("FAIL mm_sda_en: got %b want 0", sda_en_seen);
        end
        checks++;
        if ((done_cnt != 0) || (wr_cnt != 0)) begin
            failures++;
            $display("FAIL mm_done_wr: got %0d/%0d want 0/0", done_cnt, wr_cnt);
        end
        do_read(8'h01, 1, naks);
        model_ptr = 2;
        checks++;
        if (rx_q[0] !== model_bank[1]) begin
            failures++;
            $display("FAIL mm_bank: got %h want %h", rx_q[0], model_bank[1]);
        end
    endtask

    task automatic test_abort();
        logic a;
        logic [7:0] d;
        clear_mon();
        i2c_start();
        write_byte(8'hA0, a);
        write_byte(8'h01, a);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        i2c_stop();
        repeat (4) @(posedge clk);
        checks++;
        if (ack_err !== 1'b1) begin failures++; $display("FAIL abort_err: got %b want 1", ack_err); end
        checks++;
        if (wr_cnt != 0) begin failures++; $display("FAIL abort_wr: got %0d want 0", wr_cnt); end
        i2c_start();
        checks++;
        if (ack_err !== 1'b0) begin failures++; $display("FAIL abort_clear: got %b want 0", ack_err); end
        write_byte(8'hA0, a);
        write_byte(8'h01, a);
        i2c_start();
        write_byte(8'hA1, a);
        read_byte(d, 1'b1);
        i2c_stop();
        model_ptr = 2;
        checks++;
        if (d !== model_bank[1]) begin
            failures++;
            $display("FAIL abort_bank: got %h want %h", d, model_bank[1]);
        end
    endtask

    task automatic test_random();
        int naks, n, p;
        for (int it = 0; it < 6; it++) begin
            clear_mon();
            p = int'($urandom_range(DEPTH - 1, 0));
            n = int'($urandom_range(4, 1));
            tx_q.delete();
            for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
            do_write(8'(p), naks);
            repeat (4) @(posedge clk);
            model_write(p);
            checks++;
            if ((naks != 0) || (wr_cnt != n) || (done_cnt != 1)) begin
                failures++;
                $display("FAIL rnd_wr[%0d]: naks/wr/done got %0d/%0d/%0d want 0/%0d/1",
                         it, naks, wr_cnt, done_cnt, n);
            end
            for (int k = 0; k < n && k < wr_q.size(); k++) begin
                checks++;
                if (wr_q[k] !== {3'((p + k) % DEPTH), tx_q[k]}) begin
                    failures++;
                    $display("FAIL rnd_wr_beat[%0d.%0d]: got %h want %h", it, k, wr_q[k],
                             {3'((p + k) % DEPTH), tx_q[k]});
                end
            end
            p = int'($urandom_range(DEPTH - 1, 0));
            n = int'($urandom_range(4, 1));
            do_read(8'(p), n, naks);
            model_ptr = (p + n) % DEPTH;
            for (int k = 0; k < n; k++) begin
                checks++;
                if (rx_q[k] !== model_bank[(p + k) % DEPTH]) begin
                    failures++;
                    $display("FAIL rnd_rd[%0d.%0d]: got %h want %h", it, k, rx_q[k],
                             model_bank[(p + k) % DEPTH]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic a;
        logic [7:0] d0, d1;
        i2c_start();
        write_byte(8'hA0, a);
        write_byte(8'h03, a);
        i2c_start();
        write_byte(8'hA1, a);
        recv_bit(a);
        recv_bit(a);
        m_sda = 1'b1; #(Q); scl = 1'b1;
        @(posedge clk); #2;
        checks++;
        if (slave_sda_en !== 1'b1) begin
            failures++;
            $display("FAIL rmr_driving: got %b want 1", slave_sda_en);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({slave_sda_en, ssda_buffer, ack_err, done, busy, reg_wr_en, reg_wr_addr, reg_wr_data}
            !== 17'd0) begin
            failures++;
            $display("FAIL rmr_async_outputs: got %b want all zero",
                     {slave_sda_en, ssda_buffer, ack_err, done, busy, reg_wr_en});
        end
        repeat (4) @(posedge clk);
        rst = 1'b0;
        model_reset();
        repeat (4) @(posedge clk);
        i2c_start();
        write_byte(8'hA1, a);
        read_byte(d0, 1'b0);
        read_byte(d1, 1'b1);
        i2c_stop();
        checks++;
        if ({a, d0, d1} !== {1'b0, model_bank[0], model_bank[1]}) begin
            failures++;
            $display("FAIL rmr_reinit: got %b %h %h want 0 %h %h", a, d0, d1,
                     model_bank[0], model_bank[1]);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        scl = 1'b1;
        m_sda = 1'b1;
        test_reset();
        test_write_burst();
        test_read_restart();
        test_wrap();
        test_mismatch();
        test_abort();
        test_random();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
